// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Assembles little-endian words, writes them, and holds the core in reset meanwhile.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 16384,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_rst_no,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);
    localparam logic [31:0] TO_CNT    = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        accept;

    assign byte_ready_o = (state_q == RECV);
    assign mem_wren_o   = (state_q == WRITE);
    assign busy_o       = (state_q == RECV) || (state_q == WRITE);
    assign done_o       = (state_q == DONE);
    assign err_o        = (state_q == ERR);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign cpu_rst_no   = cpu_rst_q;
    assign accept       = byte_valid_i && (state_q == RECV);

    // Next-state logic: session control, byte assembly, word counting, timeout
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bidx_d  = bidx_q;
        tcnt_d  = tcnt_q;
        buf_d   = buf_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    len_d  = len_i;
                    wcnt_d = '0;
                    bidx_d = '0;
                    tcnt_d = '0;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (len_i > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    tcnt_d = '0;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Earlier bytes sit in buf_q with byte 0 lowest
                        wdata_d = {byte_data_i, buf_q};
                        addr_d  = {wcnt_q[29:0], 2'b00};
                        state_d = WRITE;
                    end else begin
                        buf_d = {byte_data_i, buf_q[23:8]};
                    end
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                    if ((TO_CNT != '0) && (tcnt_d == TO_CNT)) begin
                        state_d = ERR;
                    end
                end
            end
            WRITE: begin
                wcnt_d = wcnt_q + 32'd1;
                bidx_d = '0;
                if (wcnt_d == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cpu_rst_d = (state_d == IDLE) || (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            len_q     <= '0;
            wcnt_q    <= '0;
            bidx_q    <= '0;
            tcnt_q    <= '0;
            buf_q     <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            bidx_q    <= bidx_d;
            tcnt_q    <= tcnt_d;
            buf_q     <= buf_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Expected writes are queued at issue time and popped by a write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_wren_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_rst_no;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  stim[$];
    logic        prev_wren = 1'b0;
    logic [31:0] last_data = '0;

    imem_loader #(
        .MEM_BYTES(16384),
        .TIMEOUT  (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i (byte_data_i),
        .byte_ready_o(byte_ready_o),
        .mem_wren_o  (mem_wren_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_rst_no  (cpu_rst_no),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write cycle is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (mem_wren_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         mem_addr_o, mem_wdata_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr_o, mem_wdata_o} !== e) begin
                    errors++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             mem_addr_o, mem_wdata_o, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (byte_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: got %b expected 0", byte_ready_o);
            end
            checks++;
            if (prev_wren) begin
                errors++;
                $display("FAIL wren_width: got 2+ cycles expected 1");
            end
        end
        prev_wren = mem_wren_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    // Queue the writes a len-word load of stim[] must produce
    task automatic push_words(input int len);
        for (int w = 0; w < len; w++) begin
            logic [31:0] d;
            d = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
            exp_q.push_back({32'(w * 4), d});
            last_data = d;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        byte_valid_i = 1'b0;
        repeat (gap) tick();
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = byte_ready_o;
            @(posedge clk);
            #1;
            if (r) begin
                byte_valid_i = 1'b0;
                return;
            end
        end
        byte_valid_i = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: byte 0x%02h not accepted in 50 cycles", b);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic send_range(input int from, input int to, input int mode);
        for (int k = from; k < to; k++) begin
            int g;
            g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(stim[k], g);
        end
    endtask

    task automatic full_load(input string tag, input int len, input int mode);
        push_words(len);
        start_load(len);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_cpurst_low"}, 32'(cpu_rst_no), 32'd0);
        send_range(0, 4 * len, mode);
        tick();
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_cpurst_high"}, 32'(cpu_rst_no), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_wdata_hold"}, mem_wdata_o, last_data);
    endtask

    task automatic fixed_stim;
        logic [7:0] prog[8];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        stim.delete();
        foreach (prog[i]) stim.push_back(prog[i]);
    endtask

    task automatic rand_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        len_i        = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        repeat (3) tick();
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_wren", 32'(mem_wren_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cpurst", 32'(cpu_rst_no), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        rst_ni = 1'b1;
        tick();
        check("rel_cpurst", 32'(cpu_rst_no), 32'd1);

        fixed_stim();
        full_load("prog", 2, 0);
        fixed_stim();
        full_load("prog_toggle", 2, 1);

        // Oversize then empty load
        start_load(32'd4097);
        check("big_err", 32'(err_o), 32'd1);
        check("big_busy", 32'(busy_o), 32'd0);
        check("big_cpurst", 32'(cpu_rst_no), 32'd0);
        start_load(32'd4096 + 32'd0 - 32'd4096);
        check("zero_done", 32'(done_o), 32'd1);
        check("zero_err", 32'(err_o), 32'd0);
        check("zero_cpurst", 32'(cpu_rst_no), 32'd1);

        // Stall after two bytes
        rand_stim(4);
        start_load(32'd1);
        send_range(0, 2, 0);
        repeat (7) tick();
        check("to_early", 32'(err_o), 32'd0);
        tick();
        check("to_err", 32'(err_o), 32'd1);
        check("to_cpurst", 32'(cpu_rst_no), 32'd0);
        check("to_busy", 32'(busy_o), 32'd0);
        rand_stim(4);
        push_words(1);
        start_load(32'd1);
        check("to_clear", 32'(err_o), 32'd0);
        send_range(0, 4, 0);
        tick();
        check("to_retry_done", 32'(done_o), 32'd1);
        check("to_retry_pending", 32'(exp_q.size()), 32'd0);

        // Reset inside word 1 of a two-word load
        rand_stim(8);
        push_words(1);
        start_load(32'd2);
        send_range(0, 7, 0);
        rst_ni = 1'b0;
        tick();
        check("mid_ready", 32'(byte_ready_o), 32'd0);
        check("mid_busy", 32'(busy_o), 32'd0);
        check("mid_done", 32'(done_o), 32'd0);
        check("mid_err", 32'(err_o), 32'd0);
        check("mid_cpurst", 32'(cpu_rst_no), 32'd0);
        check("mid_addr", mem_addr_o, 32'd0);
        check("mid_wdata", mem_wdata_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("mid_rel_cpurst", 32'(cpu_rst_no), 32'd1);
        check("mid_pending", 32'(exp_q.size()), 32'd0);

        // Start during RECV is ignored
        rand_stim(4);
        push_words(1);
        start_load(32'd1);
        send_range(0, 2, 0);
        start_i = 1'b1;
        len_i   = 32'd9;
        tick();
        start_i = 1'b0;
        send_range(2, 4, 0);
        tick();
        check("ign_done", 32'(done_o), 32'd1);
        check("ign_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("ign_no_more", 32'(busy_o), 32'd0);

        // Random loads with random valid gaps
        for (int t = 0; t < 6; t++) begin
            int len;
            len = int'($urandom_range(1, 4));
            rand_stim(4 * len);
            full_load("rand", len, 2);
        end

        repeat (3) tick();
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader sitting directly upstream of the instruction memory in the single-cycle core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory's write port (write enable, byte address, write data) one word per write cycle. It holds the core in reset while a load is in progress and releases it when the programmed word count has been written. The top level muxes its address onto the memory port while `busy_o` is high.

## Interface
- `MEM_BYTES`, 16384: capacity of the target memory in bytes; loads exceeding it are rejected.
- `TIMEOUT`, 1000000: maximum consecutive RECV cycles without an accepted byte before error; 0 disables.

- `clk_i`  in  1  single clock, all state updates on rising edge
- `rst_ni`  in  1  reset, synchronous, active-low
- `start_i`  in  1  single-cycle pulse starting a load session
- `len_i`  in  32  number of words to load, sampled on accepted start
- `byte_valid_i`  in  1  byte stream valid
- `byte_data_i`  in  8  byte stream data
- `byte_ready_o`  out  1  loader can accept a byte this cycle
- `mem_wren_o`  out  1  write enable to instruction memory
- `mem_addr_o`  out  32  byte address of the word being written
- `mem_wdata_o`  out  32  assembled word
- `cpu_rst_no`  out  1  active-low reset to the core
- `busy_o`  out  1  session in progress (RECV or WRITE)
- `done_o`  out  1  last session completed successfully
- `err_o`  out  1  last session aborted (oversize or timeout)

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE/DONE/ERR with `start_i`=1: sample `len_i`, clear word counter, byte index, timeout counter, `done_o`, `err_o`.
  - `len_i`=0 → DONE.
  - `len_i`*4 > `MEM_BYTES` (computed without overflow, i.e. `len_i` > `MEM_BYTES`/4) → ERR.
  - Otherwise → RECV.
- `start_i` in RECV or WRITE is ignored.
- RECV: `byte_ready_o`=1. A byte is accepted when `byte_valid_i` && `byte_ready_o`. Byte k (0..3) of the word goes to `mem_wdata_o[8k+7:8k]`. The first byte goes to bits [7:0].
  - Acceptance of byte 3 → WRITE.
- WRITE: lasts exactly one cycle. `byte_ready_o`=0. `mem_wren_o`=1. `mem_addr_o` = word counter × 4. Word counter increments.
  - If the incremented count equals the sampled length → DONE; else → RECV with byte index 0.
- Timeout: in RECV, a counter increments each cycle with no accepted byte and clears on each accept. When it reaches `TIMEOUT` (and `TIMEOUT` ≠ 0) → ERR. A partial word is discarded and not written.
- DONE: `done_o`=1. ERR: `err_o`=1. Both flags hold until the next accepted start or reset.
- `byte_valid_i` outside RECV is not consumed; the upstream holds the byte.
- `cpu_rst_no` is registered. Each cycle it loads 1 if the next state is IDLE or DONE, else 0. The core therefore stays in reset during RECV, WRITE and ERR.

## Timing
- Reset (`rst_ni`=0 at an edge):
  - State → IDLE.
  - `byte_ready_o`, `mem_wren_o`, `busy_o`, `done_o`, `err_o`, `cpu_rst_no` → 0.
  - `mem_addr_o`, `mem_wdata_o` → 0.
  - Counters → 0.
- `cpu_rst_no` rises on the first edge with `rst_ni`=1.
- Reset mid-session: no further write occurs, the partial word is lost, the state is IDLE.
- Start accepted at edge N → RECV, `busy_o`=1 and `cpu_rst_no`=0 from N.
- Byte 3 accepted at edge M → `mem_wren_o`=1 during cycle M..M+1 → `byte_ready_o`=1 again from edge M+1 if words remain.
- Peak throughput: one byte per cycle, one write per 5 cycles.
- Last WRITE at edge W → DONE from W+1; `done_o`=1 and `cpu_rst_no`=1 from W+1.
- `mem_addr_o` and `mem_wdata_o` are stable throughout the write cycle and hold their values afterward.

## Test plan
- Reset, then start with `len_i`=2 and bytes 13 00 00 00 93 00 10 00 at one per cycle.
  - Two writes: addr 0x0 data 0x00000013, addr 0x4 data 0x00100093, each with `mem_wren_o` high exactly 1 cycle.
  - `done_o`=1, `cpu_rst_no`=1 after the second write.
- Same load with `byte_valid_i` toggled every other cycle.
  - Identical writes; no byte is dropped or duplicated; `byte_ready_o`=0 during each WRITE cycle.
- `len_i`=4097 with `MEM_BYTES`=16384 → ERR the next cycle, `err_o`=1, no write, `cpu_rst_no`=0. Then `len_i`=0 → DONE immediately with no write.
- `TIMEOUT`=8, `len_i`=1, send 2 bytes then stall.
  - ERR exactly 8 idle cycles after the 2nd byte; no write; a subsequent start clears `err_o`.
- Drop `rst_ni` after 3 bytes of word 1 of a 2-word load.
  - All outputs 0 at the next edge; no write to addr 0x4; `cpu_rst_no`=1 one edge after release.
- Pulse `start_i` with `len_i`=9 during RECV of a `len_i`=1 load.
  - Ignored: exactly 1 write, then DONE.
